// File: rtl/noc_link_arbiter.sv
// Wormhole round-robin arbiter driving one credit-flow-controlled output link.
// The link is locked to the granted requester until its tail flit is accepted.
module noc_link_arbiter #(
  parameter int unsigned NUM_INPUTS   = 4,
  parameter int unsigned FLIT_WIDTH   = 128,
  parameter int unsigned USER_WIDTH   = 32,
  parameter int unsigned DEST_WIDTH   = 8,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned CNT_WIDTH    = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS*DEST_WIDTH-1:0] in_dest,
  input  logic [NUM_INPUTS*USER_WIDTH-1:0] in_user,
  input  logic [NUM_INPUTS-1:0]            in_is_tail,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]            data_out,
  output logic [DEST_WIDTH-1:0]            dest_out,
  output logic [USER_WIDTH-1:0]            user_out,
  output logic                             is_tail_out,
  output logic                             send_out,
  input  logic                             credit_in,
  output logic [CNT_WIDTH-1:0]             credit_count,
  output logic                             busy
);

  localparam int unsigned IDX_W = $clog2(NUM_INPUTS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(BUFFER_DEPTH);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr, owner, grant_idx, acc_idx, cand;
  logic                  grant_found, has_credit, accept, acc_tail;
  logic [FLIT_WIDTH-1:0] sel_data;
  logic [DEST_WIDTH-1:0] sel_dest;
  logic [USER_WIDTH-1:0] sel_user;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NUM_INPUTS);
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !acc_tail) state_nxt = LOCKED;
      LOCKED:  if (accept && acc_tail)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and flit select; in_ready depends only on registered state and in_valid
  always_comb begin
    has_credit = (credit_count != '0);
    in_ready   = '0;
    acc_idx    = (state == LOCKED) ? owner : grant_idx;
    if (!rst && has_credit) begin
      case (state)
        IDLE:    if (grant_found) in_ready[grant_idx] = 1'b1;
        LOCKED:  in_ready[owner] = in_valid[owner];
        default: in_ready = '0;
      endcase
    end
    accept   = |(in_ready & in_valid);
    acc_tail = in_is_tail[acc_idx];
    sel_data = '0;
    sel_dest = '0;
    sel_user = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (acc_idx == IDX_W'(i)) begin
        sel_data = in_data[i*FLIT_WIDTH +: FLIT_WIDTH];
        sel_dest = in_dest[i*DEST_WIDTH +: DEST_WIDTH];
        sel_user = in_user[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  // Arbitration bookkeeping, registered link outputs and credit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      owner        <= '0;
      data_out     <= '0;
      dest_out     <= '0;
      user_out     <= '0;
      is_tail_out  <= 1'b0;
      send_out     <= 1'b0;
      busy         <= 1'b0;
      credit_count <= CNT_MAX;
    end else begin
      send_out <= accept;
      busy     <= (state_nxt == LOCKED);
      if (accept) begin
        data_out    <= sel_data;
        dest_out    <= sel_dest;
        user_out    <= sel_user;
        is_tail_out <= acc_tail;
        rr_ptr      <= acc_idx;
        if (state == IDLE) owner <= grant_idx;
      end
      case ({accept, credit_in})
        2'b10:   credit_count <= credit_count - CNT_WIDTH'(1);
        2'b01:   if (credit_count != CNT_MAX) credit_count <= credit_count + CNT_WIDTH'(1);
        default: credit_count <= credit_count;
      endcase
    end
  end

  credit_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(credit_in && credit_count == CNT_MAX))
    else $error("credit_in received with credit_count already at BUFFER_DEPTH");

endmodule

// File: doc/noc_link_arbiter.md
Name: noc_link_arbiter

Overview:
Wormhole arbiter that shares one credit-flow-controlled output link between NUM_INPUTS requesters. It chooses one requester round-robin, then locks the link to that requester until the packet's tail flit is sent. It keeps a count of free downstream buffer slots from credit returns. It drives a registered link (data/dest/user/is_tail/send) into a noc_pipeline_link or a router input port, and takes credit_in from the same link.

Parameters:
NUM_INPUTS, 4, number of requesters; must be >= 2
FLIT_WIDTH, 128, flit payload width
USER_WIDTH, 32, sideband user width
DEST_WIDTH, 8, destination field width
BUFFER_DEPTH, 8, downstream buffer slots, which is the initial credit count; must be >= 1
CNT_WIDTH, $clog2(BUFFER_DEPTH+1), credit counter width; derived, do not override

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  NUM_INPUTS*FLIT_WIDTH  flit per requester; requester i occupies slice [i*FLIT_WIDTH +: FLIT_WIDTH]
in_dest  in  NUM_INPUTS*DEST_WIDTH  destination per requester, sliced the same way
in_user  in  NUM_INPUTS*USER_WIDTH  user sideband per requester, sliced the same way
in_is_tail  in  NUM_INPUTS  flit is the last flit of its packet
in_valid  in  NUM_INPUTS  requester has a flit
in_ready  out  NUM_INPUTS  flit accepted this cycle; one-hot or zero
data_out  out  FLIT_WIDTH  link flit
dest_out  out  DEST_WIDTH  link destination
user_out  out  USER_WIDTH  link user sideband
is_tail_out  out  1  link tail marker
send_out  out  1  link flit valid, one cycle per flit
credit_in  in  1  one downstream slot freed this cycle
credit_count  out  CNT_WIDTH  current free credits, for debug and status
busy  out  1  state is LOCKED

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; rr_ptr=0; owner=0; credit_count=BUFFER_DEPTH; data_out, dest_out, user_out, is_tail_out and send_out all 0; busy=0. in_ready is 0 while rst is high.
- Accept rule: flit i is accepted when in_valid[i] and in_ready[i] are both high. in_ready[i] is computed combinationally from registered state plus in_valid, and never from credit_in.
- IDLE:
  - If credit_count > 0, grant the first valid requester at or after rr_ptr+1 (mod NUM_INPUTS), searching upward and wrapping.
  - in_ready for the granted requester is high in that same cycle.
  - If the accepted flit is not a tail, go to LOCKED with owner = granted index.
  - If it is a tail (single-flit packet), stay in IDLE.
  - After any granted packet, rr_ptr = granted index.
- LOCKED:
  - in_ready[owner] = in_valid[owner] and (credit_count > 0). All other in_ready bits are 0.
  - Other requesters' valids are ignored; the owner may insert bubbles indefinitely.
  - Accepting a tail flit returns to IDLE with rr_ptr = owner.
- Output timing: 1-cycle latency. On an accept, data/dest/user/is_tail_out capture the accepted flit and send_out is 1 in the next cycle. With no accept, send_out is 0 next cycle and the data fields hold their previous values.
- Credits:
  - Accept without credit_in: count -1.
  - credit_in without accept: count +1.
  - Both in the same cycle: count unchanged.
  - Count 0: no in_ready is asserted, and state and grant are held.
  - credit_in arriving at BUFFER_DEPTH is a protocol error: the count saturates at BUFFER_DEPTH and a simulation assertion fires.
- Throughput: one flit per cycle while credits > 0. Sustained full rate needs BUFFER_DEPTH >= the credit round trip, including link pipeline stages on both legs. This is a configuration rule, not enforced in RTL.
- Lock and valid rules:
  - A requester dropping in_valid mid-packet does not release the lock.
  - An in_is_tail value on a cycle with no accept has no effect.
- Reset mid-packet: the lock is dropped and credits return to BUFFER_DEPTH without any tail being emitted. Upstream and downstream must be reset together.

Test Plan:
- Single-flit packets with all 4 inputs valid, tails=1, credits=8 -> grant order 1,2,3,0,1; send_out high every cycle from cycle 1; each data_out equals the granted input's flit one cycle later.
- Input 2 sends a 3-flit packet while inputs 0 and 3 are valid -> in_ready[2] for 3 accepts, busy=1 until the tail, no other grant in between; next grant is input 3.
- BUFFER_DEPTH=2, no credit_in, 5 flits offered -> exactly 2 accepts, credit_count=0, in_ready=0; one credit_in pulse -> exactly one more accept, then stall again.
- Accept and credit_in in the same cycle at count=1 -> count stays 1 and streaming continues.
- Owner drops in_valid for 3 cycles mid-packet while input 0 is valid -> no grant to 0 and send_out=0 for those cycles; owner resumes and finishes, then input 0 is granted.
- rst asserted during a LOCKED packet -> all outputs 0 asynchronously, credit_count=8; after release, input 1 is granted first if valid (rr_ptr=0).
